// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
//   if_state_e  : fetch FSM state (normal fetch / draining wrong-path responses)
//   INSTR_BYTES : byte stride between consecutive instruction words
//   NOP         : canonical no-op encoding (addi x0, x0, 0)
//   if_entry_t  : one prefetch queue entry, pc in the upper half, instruction in the lower half
package if_pkg;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } if_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam int          IF_XLEN     = 32;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or when full and popping)
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   full/empty : occupancy flags, count : current occupancy
//   head       : registered copy of the oldest entry; valid when !empty
module sync_fifo #(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = head_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // The write slot equals the next read slot only when the queue drains to
      // exactly the incoming word, so the head must take push_data directly.
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end
  end

  // NOTE: storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= RESET_HEAD;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch stage.
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   IFmem_*        : word request/grant to instruction memory, in-order responses (rvalid/rdata)
//   IFredirect(_pc): taken branch/jump pulse and its target (low two bits ignored)
//   IFvalid/IFready: decoder handshake on the head {IFpc, IFinstr} of the prefetch queue
// Requests are credit limited so queued plus outstanding words never exceed DEPTH,
// which guarantees every kept response has a free queue slot.
module if_prefetch
  import if_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] IFmem_addr,
  output logic            IFmem_req,
  input  logic            IFmem_gnt,
  input  logic            IFmem_rvalid,
  input  logic [XLEN-1:0] IFmem_rdata,
  input  logic            IFredirect,
  input  logic [XLEN-1:0] IFredirect_pc,
  output logic            IFvalid,
  input  logic            IFready,
  output logic [XLEN-1:0] IFinstr,
  output logic [XLEN-1:0] IFpc
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam int             CW1     = CW + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_head;
  logic [CW:0]       credit_used;
  logic              fire, rsp, push, pop;
  logic [XLEN-1:0]   redirect_target;
  logic              redirect_pc_unused;

  // Targets are word aligned; the two low address bits are discarded.
  assign redirect_target    = {IFredirect_pc[XLEN-1:2], 2'b00};
  assign redirect_pc_unused = ^IFredirect_pc[1:0];

  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign IFmem_req   = !reset && (state_q == S_RUN) && !IFredirect &&
                       (credit_used < CW1'(DEPTH));
  assign IFmem_addr  = fetch_pc_q;
  assign fire        = IFmem_req && IFmem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp  = IFmem_rvalid && (outstanding_q != '0);
  // A response arriving with a redirect belongs to the old path.
  assign push = rsp && (drop_cnt_q == '0) && !IFredirect;
  assign pop  = IFvalid && IFready;

  assign IFvalid = !fifo_empty;
  assign IFpc    = fifo_head[2*XLEN-1:XLEN];
  assign IFinstr = fifo_head[XLEN-1:0];

  sync_fifo #(
    .WIDTH      (2 * XLEN),
    .DEPTH      (DEPTH),
    .RESET_HEAD ({RESET_PC, XLEN'(0)})
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({resp_pc_q, IFmem_rdata}),
    .pop       (pop),
    .flush     (IFredirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    state_d       = state_q;
    if (IFredirect) begin
      // Everything still in flight after this cycle is wrong-path and must be dropped.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? S_DRAIN : S_RUN;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push) resp_pc_d  = resp_pc_q + PC_STEP;
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if ((state_q == S_DRAIN) && (drop_cnt_d == '0)) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (reset)
    !(IFmem_rvalid && (outstanding_q == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: an in-order memory model answers each grant
// on demand, and every popped {pc, instr} pair is logged for comparison.
module tb_if_prefetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IFmem_addr;
  logic        IFmem_req;
  logic        IFmem_gnt;
  logic        IFmem_rvalid;
  logic [31:0] IFmem_rdata;
  logic        IFredirect;
  logic [31:0] IFredirect_pc;
  logic        IFvalid;
  logic        IFready;
  logic [31:0] IFinstr;
  logic [31:0] IFpc;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pend[$];
  if_entry_t   pops[$];
  int          n_grants;
  logic        s_req, s_valid;
  logic [31:0] s_addr;

  if_prefetch #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .IFmem_addr(IFmem_addr), .IFmem_req(IFmem_req), .IFmem_gnt(IFmem_gnt),
    .IFmem_rvalid(IFmem_rvalid), .IFmem_rdata(IFmem_rdata),
    .IFredirect(IFredirect), .IFredirect_pc(IFredirect_pc),
    .IFvalid(IFvalid), .IFready(IFready), .IFinstr(IFinstr), .IFpc(IFpc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, sample just after, log grants/pops, advance.
  // Memory word for address A is A + 0x1000_0000.
  task automatic run_cycle(input logic gnt, input logic rv, input logic ready,
                           input logic redir, input logic [31:0] rpc);
    IFmem_gnt     = gnt;
    IFready       = ready;
    IFredirect    = redir;
    IFredirect_pc = rpc;
    if (rv && pend.size() > 0) begin
      IFmem_rvalid = 1'b1;
      IFmem_rdata  = pend.pop_front() + 32'h1000_0000;
    end else begin
      IFmem_rvalid = 1'b0;
      IFmem_rdata  = '0;
    end
    #1;
    s_req   = IFmem_req;
    s_addr  = IFmem_addr;
    s_valid = IFvalid;
    if (s_req && gnt) begin
      pend.push_back(s_addr);
      n_grants++;
    end
    if (s_valid && ready) pops.push_back('{pc: IFpc, instr: IFinstr});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; IFmem_gnt = 0; IFmem_rvalid = 0; IFmem_rdata = '0;
    IFredirect = 0; IFredirect_pc = '0; IFready = 0;
    pend.delete(); pops.delete(); n_grants = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; IFmem_gnt = 1; IFmem_rvalid = 0; IFmem_rdata = '0;
    IFredirect = 0; IFredirect_pc = '0; IFready = 0;
    #1;
    n_tests++; if (IFmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_held: got %b expected 0", IFmem_req); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (IFvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IFvalid); end
    n_tests++; if (IFpc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", IFpc); end
    n_tests++; if (IFinstr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", IFinstr); end
    n_tests++; if (IFmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", IFmem_addr); end
    IFmem_gnt = 0;
    reset = 1'b0;
    #1;
    n_tests++; if (IFmem_req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %b expected 1", IFmem_req); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int first_req = -1;
    int first_valid = -1;
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_req && first_req < 0) first_req = i;
      if (s_valid && first_valid < 0) first_valid = i;
    end
    n_tests++; if (first_valid - first_req !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", first_valid - first_req); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (pops.size() <= k || pops[k].pc !== exp_pc[k] || pops[k].instr !== exp_pc[k] + 32'h1000_0000) begin
        n_fail++;
        $display("FAIL stream_pop%0d: got %h expected pc %h", k, (pops.size() > k) ? pops[k].pc : 32'hx, exp_pc[k]);
      end
    end
  endtask

  task automatic test_credit();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (n_grants !== 4) begin n_fail++; $display("FAIL credit_grants: got %0d expected 4", n_grants); end
    n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL credit_req_off: got %b expected 0", s_req); end
    n_tests++; if (IFvalid !== 1'b1 || IFpc !== 32'h0) begin n_fail++; $display("FAIL credit_head: got valid %b pc %h expected 1 00000000", IFvalid, IFpc); end
    n_grants = 0;
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (n_grants !== 1) begin n_fail++; $display("FAIL credit_one_more: got %0d expected 1", n_grants); end
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++; if (pops.size() !== 5) begin n_fail++; $display("FAIL credit_pop_count: got %0d expected 5", pops.size()); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (pops.size() <= k || pops[k].pc !== exp_pc[k] || pops[k].instr !== exp_pc[k] + 32'h1000_0000) begin
        n_fail++;
        $display("FAIL credit_pop%0d: got %h expected pc %h", k, (pops.size() > k) ? pops[k].pc : 32'hx, exp_pc[k]);
      end
    end
  endtask

  task automatic test_redirect_drain();
    logic found = 1'b0;
    do_reset();
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h103);
    n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b expected 0", s_req); end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL drain_req1: got %b expected 0", s_req); end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL drain_req2: got %b expected 0", s_req); end
    for (int i = 0; i < 4 && !found; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (s_req) begin
        found = 1'b1;
        n_tests++; if (s_addr !== 32'h100) begin n_fail++; $display("FAIL drain_addr: got %h expected 00000100", s_addr); end
      end
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL drain_timeout: got %b expected 1", found); end
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (pops.size() == 0 || pops[0].pc !== 32'h100 || pops[0].instr !== 32'h1000_0100) begin
      n_fail++;
      $display("FAIL drain_first_pc: got %h expected 00000100", (pops.size() > 0) ? pops[0].pc : 32'hx);
    end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_tests++; if (IFvalid !== 1'b1 || IFpc !== 32'h0) begin n_fail++; $display("FAIL collide_pre: got valid %b pc %h expected 1 00000000", IFvalid, IFpc); end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    n_tests++; if (pops.size() !== 1 || pops[0].pc !== 32'h0) begin n_fail++; $display("FAIL collide_pop: got %0d pops expected 1 with pc 00000000", pops.size()); end
    n_tests++; if (IFvalid !== 1'b0) begin n_fail++; $display("FAIL collide_flush: got %b expected 0", IFvalid); end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin n_fail++; $display("FAIL collide_refetch: got req %b addr %h expected 1 00000200", s_req, s_addr); end
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (pops.size() < 2 || pops[1].pc !== 32'h200 || pops[1].instr !== 32'h1000_0200) begin
      n_fail++;
      $display("FAIL collide_next_pc: got %h expected 00000200", (pops.size() > 1) ? pops[1].pc : 32'hx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr_hi: got req %b addr %h expected 1 fffffffc", s_req, s_addr); end
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr_lo: got %h expected 00000000", s_addr); end
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (pops.size() == 0 || pops[0].pc !== 32'hFFFF_FFFC || pops[0].instr !== 32'h0FFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_pop: got %h expected fffffffc", (pops.size() > 0) ? pops[0].pc : 32'hx);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    n_tests++; if (IFvalid !== 1'b1 || pend.size() !== 2) begin n_fail++; $display("FAIL midrst_pre: got valid %b pend %0d expected 1 2", IFvalid, pend.size()); end
    reset = 1'b1; IFmem_gnt = 1'b1; IFmem_rvalid = 1'b0; IFready = 1'b0;
    #1;
    n_tests++; if (IFmem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req_during: got %b expected 0", IFmem_req); end
    @(posedge clk);
    #1;
    n_tests++; if (IFvalid !== 1'b0 || IFmem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_next: got valid %b req %b expected 0 0", IFvalid, IFmem_req); end
    pend.delete(); pops.delete();
    reset = 1'b0; IFmem_gnt = 1'b0;
    #1;
    n_tests++; if (IFmem_addr !== 32'h0 || IFmem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_release: got addr %h req %b expected 00000000 1", IFmem_addr, IFmem_req); end
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_tests++;
    if (pops.size() == 0 || pops[0].pc !== 32'h0 || pops[0].instr !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL midrst_restart: got %h expected 00000000", (pops.size() > 0) ? pops[0].pc : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_redirect_drain();
    test_redirect_collide();
    test_wrap();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
